// File: rtl/tdm_pkg.sv
// tdm_pkg: shared types and constants for the 4-way TDM receive path.
//   SLOTS      - number of time slots per frame
//   slot_t     - slot index type (2 bits)
//   state_e    - receiver lock state {HUNT, RUN}
//   *_RST      - reset values used by the receiver registers
package tdm_pkg;

  localparam int unsigned SLOTS = 4;

  typedef logic [1:0] slot_t;

  typedef enum logic {
    HUNT = 1'b0,
    RUN  = 1'b1
  } state_e;

  localparam state_e STATE_RST = HUNT;
  localparam slot_t  SLOT_RST  = 2'd0;
  localparam logic   PULSE_RST = 1'b0;
  localparam logic   LANE_BIT_RST = 1'b0;

endpackage

// File: rtl/demux1x4.sv
// demux1x4: combinational 1-to-4 write-enable decoder, the structural inverse
// of the 4:1 serializing mux on the transmit side.
//   en  - input, accept condition; when low no enable is driven
//   sel - input, slot index to enable
//   we  - output, one-hot write enables (all zero when en is low)
module demux1x4
  import tdm_pkg::*;
(
  input  logic             en,
  input  slot_t            sel,
  output logic [SLOTS-1:0] we
);

  // NOTE: every always_comb output gets a default before any branch, so no
  // path leaves it unassigned and no latch is inferred.
  always_comb begin
    we = '0;
    if (en) we[sel] = 1'b1;
  end

endmodule

// File: rtl/tdm_demux4.sv
// tdm_demux4: receive end of a 4-way time-division link. Hunts for a slot-0
// sync marker, then reassembles the serialized beat stream into four
// registered lanes, publishing each complete frame with a one-cycle strobe.
//   clk         - input, rising-edge clock
//   rst         - input, synchronous active-high reset
//   din_valid   - input, beat present on din
//   sync_in     - input, marks the current beat as slot 0
//   din         - input [WIDTH], serialized beat
//   d0..d3      - output [WIDTH], registered lanes, updated on publish
//   frame_valid - output, one-cycle pulse when d0..d3 update
//   locked      - output, high while in RUN
//   slot        - output [2], slot the next accepted beat will occupy
//   sync_err    - output, one-cycle pulse after a misplaced sync
module tdm_demux4
  import tdm_pkg::*;
#(
  parameter int unsigned WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             din_valid,
  input  logic             sync_in,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] d0,
  output logic [WIDTH-1:0] d1,
  output logic [WIDTH-1:0] d2,
  output logic [WIDTH-1:0] d3,
  output logic             frame_valid,
  output logic             locked,
  output slot_t            slot,
  output logic             sync_err
);

  state_e           state, state_next;
  slot_t            slot_next;
  slot_t            wr_slot;
  logic             wr_en;
  logic             resync;
  logic [SLOTS-1:0] we;

  // Slot 3 is never stored: its beat goes straight into d3 on publish.
  logic [WIDTH-1:0] shadow [0:SLOTS-2];

  // In HUNT only a synced beat is written; in RUN every valid beat is.
  // A synced beat always lands in slot 0, which also covers resync.
  always_comb begin
    wr_en      = din_valid && (state == RUN || sync_in);
    wr_slot    = sync_in ? SLOT_RST : slot;
    resync     = din_valid && sync_in && (state == RUN) && (slot != SLOT_RST);
    slot_next  = slot;
    state_next = state;
    if (wr_en) slot_next = slot_t'(wr_slot + 2'd1);
    if (din_valid && sync_in) state_next = RUN;
  end

  demux1x4 u_demux (
    .en  (wr_en),
    .sel (wr_slot),
    .we  (we)
  );

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= STATE_RST;
      slot  <= SLOT_RST;
    end else begin
      state <= state_next;
      slot  <= slot_next;
    end
  end

  // NOTE: the shadow array is only three words, so it is cleared on reset
  // like ordinary flops rather than left to power up unknown.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < SLOTS - 1; i++) shadow[i] <= {WIDTH{LANE_BIT_RST}};
    end else begin
      for (int i = 0; i < SLOTS - 1; i++) begin
        if (we[i]) shadow[i] <= din;
      end
    end
  end

  // Publishing is keyed off the slot-3 write enable. A resync beat always
  // targets slot 0, so frame_valid and sync_err can never coincide.
  always_ff @(posedge clk) begin
    if (rst) begin
      d0          <= {WIDTH{LANE_BIT_RST}};
      d1          <= {WIDTH{LANE_BIT_RST}};
      d2          <= {WIDTH{LANE_BIT_RST}};
      d3          <= {WIDTH{LANE_BIT_RST}};
      frame_valid <= PULSE_RST;
      sync_err    <= PULSE_RST;
    end else begin
      frame_valid <= we[SLOTS-1];
      sync_err    <= resync;
      if (we[SLOTS-1]) begin
        d0 <= shadow[0];
        d1 <= shadow[1];
        d2 <= shadow[2];
        d3 <= din;
      end
    end
  end

  assign locked = (state == RUN);

endmodule

// File: tb/tb_tdm_demux4.sv
// tb_tdm_demux4: directed self-checking bench. Two instances share control
// inputs: dut1 (WIDTH=1) for the single-bit scenarios, dut4 (WIDTH=4) for
// the streaming scenario.
module tb_tdm_demux4;
  import tdm_pkg::*;

  logic       clk = 1'b0;
  logic       rst;
  logic       din_valid;
  logic       sync_in;
  logic [0:0] din1;
  logic [3:0] din4;

  logic [0:0] a0, a1, a2, a3;
  logic       a_fv, a_lk, a_se;
  slot_t      a_slot;

  logic [3:0] b0, b1, b2, b3;
  logic       b_fv, b_lk, b_se;
  slot_t      b_slot;

  int tests  = 0;
  int failed = 0;

  always #5 clk = ~clk;

  tdm_demux4 #(.WIDTH(1)) dut1 (
    .clk(clk), .rst(rst), .din_valid(din_valid), .sync_in(sync_in), .din(din1),
    .d0(a0), .d1(a1), .d2(a2), .d3(a3),
    .frame_valid(a_fv), .locked(a_lk), .slot(a_slot), .sync_err(a_se)
  );

  tdm_demux4 #(.WIDTH(4)) dut4 (
    .clk(clk), .rst(rst), .din_valid(din_valid), .sync_in(sync_in), .din(din4),
    .d0(b0), .d1(b1), .d2(b2), .d3(b3),
    .frame_valid(b_fv), .locked(b_lk), .slot(b_slot), .sync_err(b_se)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Drive one cycle on the falling edge, then sample 1 time unit after the
  // rising edge that consumed it.
  task automatic step(input logic r, input logic v, input logic s, input logic [3:0] d);
    @(negedge clk);
    rst       = r;
    din_valid = v;
    sync_in   = s;
    din1      = d[0:0];
    din4      = d;
    @(posedge clk);
    #1;
  endtask

  task automatic lanes1(input string tag, input logic [3:0] e);
    chk({tag, ".d0"}, {31'd0, a0}, {31'd0, e[3]});
    chk({tag, ".d1"}, {31'd0, a1}, {31'd0, e[2]});
    chk({tag, ".d2"}, {31'd0, a2}, {31'd0, e[1]});
    chk({tag, ".d3"}, {31'd0, a3}, {31'd0, e[0]});
  endtask

  initial begin
    rst = 1'b1; din_valid = 1'b0; sync_in = 1'b0; din1 = '0; din4 = '0;

    // Reset state
    step(1, 0, 0, 0);
    step(1, 0, 0, 0);
    lanes1("rst", 4'b0000);
    chk("rst.fv", a_fv, 0);
    chk("rst.se", a_se, 0);
    chk("rst.locked", a_lk, 0);
    chk("rst.slot", a_slot, 0);
    chk("rst.w4.d0", b0, 0);

    // Lock and frame: beats 1,0,1,1 with sync on the first
    step(0, 1, 1, 1);
    chk("lock.locked", a_lk, 1);
    chk("lock.slot1", a_slot, 1);
    chk("lock.fv0", a_fv, 0);
    step(0, 1, 0, 0);
    chk("lock.slot2", a_slot, 2);
    step(0, 1, 0, 1);
    chk("lock.slot3", a_slot, 3);
    chk("lock.fv_early", a_fv, 0);
    step(0, 1, 0, 1);
    chk("lock.fv", a_fv, 1);
    chk("lock.slot_wrap", a_slot, 0);
    lanes1("lock", 4'b1011);
    step(0, 0, 0, 0);
    chk("lock.fv_pulse", a_fv, 0);
    lanes1("lock.hold", 4'b1011);

    // Hunt ignore: unsynced beats after reset
    step(1, 0, 0, 0);
    step(1, 0, 0, 0);
    for (int i = 0; i < 3; i++) begin
      step(0, 1, 0, 1);
      chk("hunt.fv", a_fv, 0);
      chk("hunt.slot", a_slot, 0);
    end
    chk("hunt.locked", a_lk, 0);
    lanes1("hunt", 4'b0000);

    // Stall: 3 idle cycles between slot 1 and slot 2
    step(1, 0, 0, 0);
    step(0, 1, 1, 0);
    step(0, 1, 0, 1);
    chk("stall.slot2", a_slot, 2);
    for (int i = 0; i < 3; i++) begin
      step(0, 0, 0, 0);
      chk("stall.hold", a_slot, 2);
      chk("stall.fv_gap", a_fv, 0);
    end
    step(0, 1, 0, 1);
    chk("stall.slot3", a_slot, 3);
    chk("stall.fv_early", a_fv, 0);
    step(0, 1, 0, 0);
    chk("stall.fv", a_fv, 1);
    lanes1("stall", 4'b0110);
    step(0, 0, 0, 0);
    chk("stall.fv_once", a_fv, 0);

    // Resync: 1,1 then synced 0 at slot 2, then 1,1,0
    step(1, 0, 0, 0);
    step(0, 1, 1, 1);
    step(0, 1, 0, 1);
    chk("resync.slot2", a_slot, 2);
    step(0, 1, 1, 0);
    chk("resync.se", a_se, 1);
    chk("resync.slot1", a_slot, 1);
    chk("resync.fv_drop", a_fv, 0);
    lanes1("resync.drop", 4'b0000);
    step(0, 1, 0, 1);
    chk("resync.se_pulse", a_se, 0);
    chk("resync.locked", a_lk, 1);
    step(0, 1, 0, 1);
    chk("resync.fv_early", a_fv, 0);
    step(0, 1, 0, 0);
    chk("resync.fv", a_fv, 1);
    chk("resync.se_clear", a_se, 0);
    lanes1("resync", 4'b0110);

    // Reset mid-frame, with a synced beat presented during reset
    step(0, 1, 1, 1);
    step(0, 1, 0, 1);
    chk("midrst.slot_pre", a_slot, 2);
    step(1, 1, 1, 1);
    chk("midrst.locked", a_lk, 0);
    chk("midrst.slot", a_slot, 0);
    chk("midrst.fv", a_fv, 0);
    lanes1("midrst", 4'b0000);
    for (int i = 0; i < 4; i++) begin
      step(0, 1, 0, 1);
      chk("midrst.ign_fv", a_fv, 0);
    end
    chk("midrst.ign_locked", a_lk, 0);
    chk("midrst.ign_slot", a_slot, 0);
    lanes1("midrst.ign", 4'b0000);

    // Streaming at WIDTH=4: values 1..12, sync on each slot-0 beat
    step(1, 0, 0, 0);
    for (int k = 1; k <= 12; k++) begin
      step(0, 1, (k % 4) == 1, 4'(k));
      chk("stream.fv", b_fv, (k % 4) == 0);
      chk("stream.se", b_se, 0);
      if ((k % 4) == 0) begin
        chk("stream.d0", b0, k - 3);
        chk("stream.d1", b1, k - 2);
        chk("stream.d2", b2, k - 1);
        chk("stream.d3", b3, k);
      end
    end
    step(0, 0, 0, 0);
    chk("stream.fv_end", b_fv, 0);
    chk("stream.hold_d3", b3, 12);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
